// File: rtl/disp_share_arb.sv
// Round-robin arbiter sharing the 4-digit seven-segment display among four requesters.
// Optional macro DISP_SHARE_BLINK_EN blinks the shown word every 250 ce1ms ticks.
module disp_share_arb #(
    parameter int unsigned DWELL_MS = 1000,
    parameter logic [15:0] IDLE_DAT = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce1ms,
    input  logic [3:0]  req,
    input  logic [63:0] req_dat,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic [15:0] dat,
    output logic        busy
);

    localparam int unsigned CW = $clog2(DWELL_MS + 1);

    typedef enum logic {IDLE, SHOW} state_t;

    state_t        state, state_n;
    logic [1:0]    ptr, ptr_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [3:0]    gnt_n, done_n;
    logic [15:0]   dat_n;
    logic          busy_n;
    logic [1:0]    win;
    logic          found;

`ifdef DISP_SHARE_BLINK_EN
    logic [7:0]    phase, phase_n;
    logic          vis, vis_n;
    logic [15:0]   word, word_n;
`endif

    // First requester at or after ptr+1, wrapping modulo 4.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            if (!found && req[ptr + 2'(k)]) begin
                found = 1'b1;
                win   = ptr + 2'(k);
            end
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        cnt_n   = cnt;
        gnt_n   = gnt;
        done_n  = '0;
        dat_n   = dat;
`ifdef DISP_SHARE_BLINK_EN
        phase_n = phase;
        vis_n   = vis;
        word_n  = word;
`endif
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = SHOW;
                    gnt_n   = 4'b0001 << win;
                    dat_n   = req_dat[{win, 4'b0000} +: 16];
                    ptr_n   = win;
                    cnt_n   = '0;
`ifdef DISP_SHARE_BLINK_EN
                    word_n  = req_dat[{win, 4'b0000} +: 16];
                    phase_n = '0;
                    vis_n   = 1'b1;
`endif
                end
            end
            SHOW: begin
                // ptr already holds the current grantee, so abort leaves it advanced past g.
                if (!req[ptr]) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    dat_n   = IDLE_DAT;
                end else if (ce1ms) begin
                    if (cnt == CW'(DWELL_MS - 1)) begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        dat_n   = IDLE_DAT;
                        done_n  = 4'b0001 << ptr;
                    end else begin
                        cnt_n = cnt + 1'b1;
`ifdef DISP_SHARE_BLINK_EN
                        if (phase == 8'd249) begin
                            phase_n = '0;
                            vis_n   = !vis;
                            dat_n   = vis ? IDLE_DAT : word;
                        end else begin
                            phase_n = phase + 8'd1;
                        end
`endif
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == SHOW);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= 2'd3;
            cnt   <= '0;
            gnt   <= '0;
            done  <= '0;
            dat   <= IDLE_DAT;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            ptr   <= ptr_n;
            cnt   <= cnt_n;
            gnt   <= gnt_n;
            done  <= done_n;
            dat   <= dat_n;
            busy  <= busy_n;
        end
    end

`ifdef DISP_SHARE_BLINK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
            vis   <= 1'b1;
            word  <= IDLE_DAT;
        end else begin
            phase <= phase_n;
            vis   <= vis_n;
            word  <= word_n;
        end
    end
`endif

endmodule

// File: tb/tb_disp_share_arb.sv
// Directed, table-driven bench for disp_share_arb with DWELL_MS=4.
module tb_disp_share_arb;

    localparam logic [63:0] D  = 64'h3333_BEEF_1111_1234;
    localparam logic [63:0] D2 = 64'h3333_BEEF_1111_5678;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce1ms;
    logic [3:0]  req;
    logic [63:0] req_dat;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic [15:0] dat;
    logic        busy;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    disp_share_arb #(.DWELL_MS(4), .IDLE_DAT(16'h0000)) dut (
        .clk     (clk),
        .rst     (rst),
        .ce1ms   (ce1ms),
        .req     (req),
        .req_dat (req_dat),
        .gnt     (gnt),
        .done    (done),
        .dat     (dat),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ce;
        logic [3:0]  req;
        logic [63:0] rd;
        logic [3:0]  gnt;
        logic [3:0]  done;
        logic [15:0] dat;
        logic        busy;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input int n, input logic r, input logic c, input logic [3:0] q,
                       input logic [63:0] d, input logic [3:0] g, input logic [3:0] dn,
                       input logic [15:0] dt, input logic b);
        vec_t v;
        v.rst = r; v.ce = c; v.req = q; v.rd = d;
        v.gnt = g; v.done = dn; v.dat = dt; v.busy = b;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        rst = 1'b1; ce1ms = 1'b0; req = '0; req_dat = D;

        // reset with all requests high
        add(2, 1, 0, 4'b1111, D, 4'b0000, 4'b0000, 16'h0000, 0);
        // single grant to requester 2, done on the 4th tick
        add(1, 0, 0, 4'b0100, D, 4'b0100, 4'b0000, 16'hBEEF, 1);
        add(1, 0, 1, 4'b0100, D, 4'b0100, 4'b0000, 16'hBEEF, 1);
        add(1, 0, 0, 4'b0100, D, 4'b0100, 4'b0000, 16'hBEEF, 1);
        add(2, 0, 1, 4'b0100, D, 4'b0100, 4'b0000, 16'hBEEF, 1);
        add(1, 0, 1, 4'b0100, D, 4'b0000, 4'b0100, 16'h0000, 0);
        add(1, 0, 0, 4'b0000, D, 4'b0000, 4'b0000, 16'h0000, 0);
        add(1, 0, 1, 4'b0000, D, 4'b0000, 4'b0000, 16'h0000, 0);
        add(1, 1, 0, 4'b0000, D, 4'b0000, 4'b0000, 16'h0000, 0);
        // round robin 0,1,2,3,0 with slice 0 changed mid-dwell
        add(1, 0, 0, 4'b1111, D,  4'b0001, 4'b0000, 16'h1234, 1);
        add(1, 0, 1, 4'b1111, D,  4'b0001, 4'b0000, 16'h1234, 1);
        add(2, 0, 1, 4'b1111, D2, 4'b0001, 4'b0000, 16'h1234, 1);
        add(1, 0, 1, 4'b1111, D,  4'b0000, 4'b0001, 16'h0000, 0);
        add(1, 0, 0, 4'b1111, D,  4'b0010, 4'b0000, 16'h1111, 1);
        add(3, 0, 1, 4'b1111, D,  4'b0010, 4'b0000, 16'h1111, 1);
        add(1, 0, 1, 4'b1111, D,  4'b0000, 4'b0010, 16'h0000, 0);
        add(1, 0, 0, 4'b1111, D,  4'b0100, 4'b0000, 16'hBEEF, 1);
        add(3, 0, 1, 4'b1111, D,  4'b0100, 4'b0000, 16'hBEEF, 1);
        add(1, 0, 1, 4'b1111, D,  4'b0000, 4'b0100, 16'h0000, 0);
        add(1, 0, 0, 4'b1111, D,  4'b1000, 4'b0000, 16'h3333, 1);
        add(3, 0, 1, 4'b1111, D,  4'b1000, 4'b0000, 16'h3333, 1);
        add(1, 0, 1, 4'b1111, D,  4'b0000, 4'b1000, 16'h0000, 0);
        add(1, 0, 0, 4'b1111, D,  4'b0001, 4'b0000, 16'h1234, 1);
        add(3, 0, 1, 4'b1111, D,  4'b0001, 4'b0000, 16'h1234, 1);
        add(1, 0, 1, 4'b1111, D,  4'b0000, 4'b0001, 16'h0000, 0);
        // requester 1 aborts after 2 ticks, requester 2 follows
        add(1, 0, 0, 4'b1111, D,  4'b0010, 4'b0000, 16'h1111, 1);
        add(2, 0, 1, 4'b1111, D,  4'b0010, 4'b0000, 16'h1111, 1);
        add(1, 0, 0, 4'b1101, D,  4'b0000, 4'b0000, 16'h0000, 0);
        add(1, 0, 0, 4'b1101, D,  4'b0100, 4'b0000, 16'hBEEF, 1);
        add(3, 0, 1, 4'b1101, D,  4'b0100, 4'b0000, 16'hBEEF, 1);
        // abort coincides with the final tick: no done
        add(1, 0, 1, 4'b1001, D,  4'b0000, 4'b0000, 16'h0000, 0);
        add(1, 0, 0, 4'b0000, D,  4'b0000, 4'b0000, 16'h0000, 0);
        // reset during SHOW, then requester 0 regains first priority
        add(1, 0, 0, 4'b0001, D,  4'b0001, 4'b0000, 16'h1234, 1);
        add(1, 1, 1, 4'b0001, D,  4'b0000, 4'b0000, 16'h0000, 0);
        add(1, 0, 0, 4'b0000, D,  4'b0000, 4'b0000, 16'h0000, 0);
        add(1, 0, 0, 4'b1001, D,  4'b0001, 4'b0000, 16'h1234, 1);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; ce1ms = vecs[i].ce; req = vecs[i].req; req_dat = vecs[i].rd;
            @(posedge clk);
            #1;
            n_vec++;
            if (gnt !== vecs[i].gnt || done !== vecs[i].done ||
                dat !== vecs[i].dat || busy !== vecs[i].busy) begin
                n_bad++;
                $display("FAIL vec%0d: got gnt=%b done=%b dat=%h busy=%b, want gnt=%b done=%b dat=%h busy=%b",
                         i, gnt, done, dat, busy, vecs[i].gnt, vecs[i].done, vecs[i].dat, vecs[i].busy);
            end
        end

        // requester 0 drops out; requester 3 is served with a sparse tick stream
        @(negedge clk);
        rst = 1'b0; ce1ms = 1'b0; req = 4'b1000; req_dat = D;
        @(posedge clk);
        #1;
        n_vec++;
        if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL abort0: got gnt=%b busy=%b, want gnt=0000 busy=0", gnt, busy);
        end

        begin
            int unsigned ticks;
            logic        was_busy;
            logic        seen;
            logic [3:0]  dn;
            logic [3:0]  g3;
            ticks = 0; seen = 1'b0; dn = '0; g3 = '0;
            for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
                @(negedge clk);
                ce1ms = (cyc % 3 == 0);
                was_busy = busy;
                @(posedge clk);
                #1;
                if (ce1ms && was_busy) ticks++;
                if (gnt != 4'b0000) g3 = gnt;
                if (done != 4'b0000) begin
                    seen = 1'b1;
                    dn = done;
                end
            end
            n_vec++;
            if (!seen || dn !== 4'b1000 || ticks != 4 || g3 !== 4'b1000) begin
                n_bad++;
                $display("FAIL sparse_dwell: got seen=%b done=%b ticks=%0d gnt=%b, want seen=1 done=1000 ticks=4 gnt=1000",
                         seen, dn, ticks, g3);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/disp_share_arb.md
# disp_share_arb

Round-robin arbiter that shares the 4-digit seven-segment display among four requesters. Each requester asks for the display with a level request and a 16-bit hex word. The winner's word is latched and driven onto the display's `dat` input for a fixed dwell time, counted in the display's own 1 ms enable ticks. The block sits between the application sources and the display driver: it consumes the driver's `ce1ms` and drives its `dat`.

## Interface
- `DWELL_MS`, default 1000: dwell per grant in `ce1ms` ticks; legal range 1..65535.
- `IDLE_DAT`, default 16'h0000: word shown when no grant is active.
- `clk` in, 1: system clock.
- `rst` in, 1: one clock; reset is synchronous and active-high.
- `ce1ms` in, 1: one-cycle 1 ms tick from the display driver.
- `req` in, 4: level request per requester; bit i belongs to requester i.
- `req_dat` in, 64: requester i's word on bits [16i+15:16i].
- `gnt` out, 4: one-hot grant, or all zero.
- `done` out, 4: one-cycle pulse on bit i when requester i's dwell completes normally.
- `dat` out, 16: word to the display driver.
- `busy` out, 1: high while in SHOW.

## Operation
- State machine with two states: IDLE and SHOW.
- Reset state: IDLE, `gnt`=0, `done`=0, `dat`=`IDLE_DAT`, `busy`=0, dwell counter=0, last-granted pointer=3 (requester 0 has first priority).
- Transitions out of IDLE:
  - If `req` is non-zero, pick the first set bit searching upward from last+1 and wrapping modulo 4.
  - On the next edge, enter SHOW, set `gnt`, latch `req_dat` for the winner into `dat`, set the pointer to the winner, and clear the counter.
- Behaviour in SHOW:
  - Each `ce1ms` increments the counter.
  - `req` and `req_dat` changes are ignored except for the abort rule below.
- Normal end of SHOW: `ce1ms` high while counter==`DWELL_MS`-1. On that edge:
  - pulse `done`[g];
  - clear `gnt`;
  - set `dat`=`IDLE_DAT`;
  - return to IDLE.
- Abort: `req`[g] low in SHOW.
  - On the next edge, return to IDLE, clear `gnt`, set `dat`=`IDLE_DAT`, no `done` pulse.
  - The pointer still advances past g.
- If abort and the dwell-end condition occur in the same cycle, abort wins: no `done`.
- A requester that keeps `req` high after `done` is re-eligible, but round-robin serves other pending requesters first.
- Counter width is `$clog2(DWELL_MS+1)`. It never wraps because it clears on every grant.
- `rst` in SHOW returns everything to reset values on the next edge. No `done` pulse is issued.

## Timing
- Request-to-grant latency: 1 cycle (`req` seen at edge N gives `gnt`/`dat` valid after edge N+1).
- Dwell: exactly `DWELL_MS` `ce1ms` pulses, counted from the first pulse after the grant edge.
- Gap: one IDLE cycle minimum between consecutive grants.
- Outputs are all registered.
- `ce1ms` pulses arriving in IDLE are ignored.

## Configuration
- Macro `DISP_SHARE_BLINK_EN`.
- Defined: during SHOW, `dat` alternates between the latched word and `IDLE_DAT` every 250 `ce1ms` ticks, using an internal 8-bit phase counter.
  - Phase resets to "latched word shown" at each grant.
  - `done`/`gnt` timing is unchanged.
- Undefined: `dat` holds the latched word for the whole dwell. No phase counter is synthesized.

## Test plan
- **Reset values:** `rst`=1 for 2 cycles with `req`=4'b1111 → `gnt`=0, `dat`=16'h0000, `busy`=0 throughout.
- **Single grant:** `DWELL_MS`=4; `req`=4'b0100, slice 2 = 16'hBEEF.
  - `gnt`=4'b0100 one cycle later, `dat`=16'hBEEF.
  - `done`=4'b0100 exactly on the 4th `ce1ms`.
  - `dat` back to 16'h0000.
- **Round-robin:** `req`=4'b1111 held, each slice distinct → grant order 0,1,2,3,0, each grant lasting 4 ticks, one IDLE cycle between grants.
- **Abort:** requester 1 granted; drop `req`[1] after 2 ticks → `gnt`=0 next cycle, no `done`, next grant goes to requester 2 if pending.
- **Latch and ignore:** change `req_dat` slice 0 mid-SHOW from 16'h1234 to 16'h5678 → `dat` stays 16'h1234.
- **Blink (macro defined):** `DWELL_MS`=1000 → `dat` = word for ticks 0-249, `IDLE_DAT` for 250-499, word for 500-749, `IDLE_DAT` for 750-999, then `done`.
